// File: rtl/cpu_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_writeback
//  Purpose  : Write-back stage feeding the register-file write port. Accepts
//             ALU and load results (load has fixed priority), drops writes to
//             x0, buffers results in an in-order circular queue and drains
//             one entry per cycle unless stalled. Two bypass ports return the
//             youngest queued (not yet committed) value for a register.
//  Ports    : clk, reset (sync, active-low)
//             alu_valid/alu_ready/alu_rd/alu_data   - ALU producer
//             lsu_valid/lsu_ready/lsu_rd/lsu_data   - load producer
//             wb_stall                               - hold head, no write
//             rd_addr/rd_data/rd_write_en            - register-file port
//             byp_rs{1,2}_addr/_hit/_data            - bypass lookups
//             wb_count/wb_empty/wb_full              - queue status
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_writeback #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [4:0]                 lsu_rd,
    input  logic [XLEN-1:0]            lsu_data,
    input  logic                       wb_stall,
    output logic [4:0]                 rd_addr,
    output logic [XLEN-1:0]            rd_data,
    output logic                       rd_write_en,
    input  logic [4:0]                 byp_rs1_addr,
    input  logic [4:0]                 byp_rs2_addr,
    output logic                       byp_rs1_hit,
    output logic                       byp_rs2_hit,
    output logic [XLEN-1:0]            byp_rs1_data,
    output logic [XLEN-1:0]            byp_rs2_data,
    output logic [$clog2(DEPTH):0]     wb_count,
    output logic                       wb_empty,
    output logic                       wb_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DEPTH);

    // Queue storage and bookkeeping
    logic [4:0]       r_rd   [DEPTH];
    logic [XLEN-1:0]  r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_lsu_acc;
    logic             w_alu_acc;
    logic             w_enq;
    logic             w_deq;
    logic [4:0]       w_enq_rd;
    logic [XLEN-1:0]  w_enq_data;

    // ------------------------------------------------------------------
    // Status and handshake
    // ------------------------------------------------------------------
    assign w_full   = (r_count == c_FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign wb_full  = w_full;
    assign wb_empty = w_empty;
    assign wb_count = r_count;

    // Ready depends only on occupancy and LSU presence; a same-cycle drain
    // never frees a slot for a same-cycle enqueue.
    assign lsu_ready = !w_full;
    assign alu_ready = !w_full && !lsu_valid;

    assign w_lsu_acc = lsu_valid && lsu_ready;
    assign w_alu_acc = alu_valid && alu_ready;

    always_comb begin
        w_enq_rd   = alu_rd;
        w_enq_data = alu_data;
        if (w_lsu_acc) begin
            w_enq_rd   = lsu_rd;
            w_enq_data = lsu_data;
        end
    end

    // Writes to x0 complete the handshake but are never stored.
    assign w_enq = (w_lsu_acc || w_alu_acc) && (w_enq_rd != 5'd0);

    // ------------------------------------------------------------------
    // Drain to register file
    // ------------------------------------------------------------------
    assign rd_write_en = !w_empty && !wb_stall;
    assign w_deq       = rd_write_en;
    assign rd_addr     = w_empty ? 5'd0 : r_rd[r_rptr];
    assign rd_data     = w_empty ? '0   : r_data[r_rptr];

    // ------------------------------------------------------------------
    // Pointer, occupancy and valid-bit state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            // Enqueue and dequeue never target the same slot: enqueue needs
            // a non-full queue and dequeue a non-empty one, so wptr != rptr
            // whenever both are active.
            if (w_enq) begin
                r_valid[r_wptr] <= 1'b1;
                r_wptr          <= r_wptr + 1'b1;
            end
            if (w_deq) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_rd[r_wptr]   <= w_enq_rd;
            r_data[r_wptr] <= w_enq_data;
        end
    end

    // ------------------------------------------------------------------
    // Bypass lookup: scan from head (oldest) toward tail (youngest) so the
    // last match found is the most recently enqueued one.
    // ------------------------------------------------------------------
    logic [4:0]      w_lk_addr [2];
    logic            w_lk_hit  [2];
    logic [XLEN-1:0] w_lk_data [2];

    assign w_lk_addr[0] = byp_rs1_addr;
    assign w_lk_addr[1] = byp_rs2_addr;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_byp
            logic [PTR_W-1:0] w_idx;
            always_comb begin
                w_lk_hit[p]  = 1'b0;
                w_lk_data[p] = '0;
                w_idx        = r_rptr;
                for (int k = 0; k < DEPTH; k++) begin
                    w_idx = r_rptr + PTR_W'(k);
                    if (r_valid[w_idx] && (r_rd[w_idx] == w_lk_addr[p]) &&
                        (w_lk_addr[p] != 5'd0)) begin
                        w_lk_hit[p]  = 1'b1;
                        w_lk_data[p] = r_data[w_idx];
                    end
                end
            end
        end
    endgenerate

    assign byp_rs1_hit  = w_lk_hit[0];
    assign byp_rs1_data = w_lk_data[0];
    assign byp_rs2_hit  = w_lk_hit[1];
    assign byp_rs2_data = w_lk_data[1];

endmodule
`default_nettype wire
